// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: front-end sequencer for the 8-bit combinational ALU.
// It takes one operation over op_valid/op_ready and drives it to the ALU as
// {op_code, op_a, op_b}. It waits SETTLE_CYCLES edges, captures the ALU result
// and flags, and returns them over res_valid/res_ready.
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1        // legal 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic [17:0] instruction,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_ext,
  input  logic        alu_ovf,
  input  logic        alu_carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_ovf,
  output logic        res_carry,
  output logic        busy,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [1:0] OP_MUL    = 2'b11;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] cnt;

  // Handshake status decodes from the state register only, so no input
  // reaches an output combinationally.
  assign op_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Issue/settle/return sequencer; all datapath outputs are registered here.
  // The opcode used at capture is the latched one, never the live op_code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      instruction <= 18'h0;
      res_valid   <= 1'b0;
      res_data    <= 16'h0;
      res_ovf     <= 1'b0;
      res_carry   <= 1'b0;
      op_count    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            instruction <= {op_code, op_a, op_b};
            cnt         <= SETTLE_LD;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd1) begin
            res_data  <= (instruction[17:16] == OP_MUL) ? {alu_ext, alu_out}
                                                        : {8'h00, alu_out};
            res_ovf   <= alu_ovf;
            res_carry <= alu_carry;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Result data and flags are held after the handshake until the next capture.
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
